// File: rtl/coproc_cmd_ctrl.sv
// coproc_cmd_ctrl: Avalon-MM slave that issues one command at a time to the
// processing engine. It provides a start/abort control register, a valid/ready
// command handshake, completion tracking with a watchdog, sticky status bits
// and a level interrupt. readdata is combinational on address.
module coproc_cmd_ctrl #(
  parameter int CMD_W = 32,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [CMD_W-1:0] cmd_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  input  logic             eng_done,
  input  logic             eng_error,
  output logic             busy,
  output logic             irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [CMD_W-1:0]  r_cmd;
  logic [TO_W-1:0]   r_timeout;
  logic [TO_W-1:0]   r_cnt;
  logic              r_irq_en;
  // sticky bits: [0] DONE, [1] ERROR, [2] TIMEOUT, [3] OVERRUN
  logic [3:0]        r_sticky;

  logic              w_wr;
  logic              w_wr_ctrl;
  logic              w_wr_cmd;
  logic              w_wr_stat;
  logic              w_wr_to;
  logic              w_start;
  logic              w_abort;
  logic              w_load;
  logic [3:0]        w_set;
  logic [3:0]        w_clr;
  logic              w_unused;

  assign w_wr      = chipselect & ~write_n;
  assign w_wr_ctrl = w_wr & (address == 2'd0);
  assign w_wr_cmd  = w_wr & (address == 2'd1);
  assign w_wr_stat = w_wr & (address == 2'd2);
  assign w_wr_to   = w_wr & (address == 2'd3);
  // ABORT dominates START when both bits are written together
  assign w_abort   = w_wr_ctrl & writedata[1];
  assign w_start   = w_wr_ctrl & writedata[0] & ~writedata[1];
  assign w_clr     = w_wr_stat ? writedata[4:1] : 4'b0000;
  assign w_unused  = &{1'b0, writedata};

  assign busy      = (r_state != S_IDLE);
  assign cmd_valid = (r_state == S_ISSUE);
  assign cmd_data  = r_cmd;
  assign irq       = r_irq_en & (|r_sticky[2:0]);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state, watchdog load and status-set events
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_set  = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_abort) begin
          w_next = S_IDLE;
        end else if (cmd_ready) begin
          w_next = S_WAIT;
          w_load = 1'b1;
        end
      end
      S_WAIT: begin
        // abort is silent; done beats a simultaneous watchdog expiry
        if (w_abort) begin
          w_next = S_IDLE;
        end else if (eng_done) begin
          w_next   = S_IDLE;
          w_set[0] = 1'b1;
          w_set[1] = eng_error;
        end else if ((r_timeout != '0) && (r_cnt == CNT_ONE)) begin
          w_next   = S_IDLE;
          w_set[2] = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if ((r_state != S_IDLE) && (w_start || w_wr_cmd)) w_set[3] = 1'b1;
  end

  // Watchdog counter: loaded on handshake, counts down in WAIT, parks at 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= r_timeout;
    end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // Software-visible registers; CMD is frozen while a transaction is open
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd     <= '0;
      r_timeout <= '0;
      r_irq_en  <= 1'b0;
    end else begin
      if (w_wr_ctrl)                       r_irq_en  <= writedata[2];
      if (w_wr_cmd && (r_state == S_IDLE)) r_cmd     <= writedata[CMD_W-1:0];
      if (w_wr_to)                         r_timeout <= writedata[TO_W-1:0];
    end
  end

  // Sticky status: a set in the same cycle as a W1C clear wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sticky <= 4'b0000;
    else          r_sticky <= (r_sticky & ~w_clr) | w_set;
  end

  // Zero-wait read mux
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[2]          = r_irq_en;
      2'd1:    readdata[CMD_W-1:0]  = r_cmd;
      2'd2:    readdata[4:0]        = {r_sticky, busy};
      default: readdata[TO_W-1:0]   = r_timeout;
    endcase
  end

endmodule

// File: tb/tb_coproc_cmd_ctrl.sv
// Scoreboard bench for coproc_cmd_ctrl. The stimulus process pushes the
// expected command word and completion record for each transaction; a monitor
// on the falling edge pops and compares at every handshake and every return
// to idle. Register reads are compared directly by the stimulus process.
module tb_coproc_cmd_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        eng_done = 1'b0;
  logic        eng_error = 1'b0;
  logic        busy;
  logic        irq;

  coproc_cmd_ctrl #(.CMD_W(32), .TO_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .eng_done(eng_done), .eng_error(eng_error), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned wc;   // WAIT cycles from handshake to idle
    logic        irq;  // irq level in the first idle cycle
  } end_t;

  logic [31:0] q_cmd[$];
  end_t        q_end[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        in_wait = 1'b0;
  int unsigned wcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    cyc();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
    chipselect = 1'b1; address = a;
    #1;
    chk(nm, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic push(input logic [31:0] c, input int unsigned wc, input logic ir);
    end_t e;
    e.wc = wc; e.irq = ir;
    q_cmd.push_back(c);
    q_end.push_back(e);
  endtask

  // Monitor: handshake -> check command, return to idle -> check duration and irq
  always @(negedge clk) begin
    if (!reset_n) begin
      in_wait = 1'b0;
    end else if (cmd_valid && cmd_ready) begin
      if (q_cmd.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_handshake: got cmd 0x%0h, expected none", cmd_data);
      end else begin
        chk("handshake_cmd_data", cmd_data, q_cmd.pop_front());
      end
      in_wait = 1'b1;
      wcnt = 0;
    end else if (in_wait) begin
      if (busy) begin
        wcnt++;
      end else begin
        in_wait = 1'b0;
        if (q_end.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_completion: got %0d wait cycles, expected none", wcnt);
        end else begin
          end_t e;
          e = q_end.pop_front();
          chk("wait_cycles", wcnt, e.wc);
          chk("irq_at_end", {31'd0, irq}, {31'd0, e.irq});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    repeat (3) cyc();
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_cmd_data", cmd_data, 32'd0);
    rd("rst_ctrl", 2'd0, 32'd0);
    rd("rst_cmd", 2'd1, 32'd0);
    rd("rst_status", 2'd2, 32'd0);
    rd("rst_timeout", 2'd3, 32'd0);
    reset_n = 1'b1;
    cyc();

    // reset in the middle of WAIT with the counter running
    wr(2'd3, 32'd100);
    wr(2'd1, 32'h11);
    q_cmd.push_back(32'h11);
    cmd_ready = 1'b1;
    wr(2'd0, 32'h1);
    cyc();
    cmd_ready = 1'b0;
    repeat (3) cyc();
    chk("midwait_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("inrst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("inrst_busy", {31'd0, busy}, 32'd0);
    chk("inrst_irq", {31'd0, irq}, 32'd0);
    chk("inrst_cmd_data", cmd_data, 32'd0);
    rd("inrst_status", 2'd2, 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();
    rd("postrst_timeout", 2'd3, 32'd0);

    // normal command: ready 2 cycles after start, done in the 4th WAIT cycle
    wr(2'd1, 32'hA5);
    wr(2'd0, 32'h4);
    push(32'hA5, 4, 1'b1);
    wr(2'd0, 32'h5);
    chk("issue_valid", {31'd0, cmd_valid}, 32'd1);
    chk("issue_busy", {31'd0, busy}, 32'd1);
    cyc();
    cmd_ready = 1'b1;
    cyc();
    cmd_ready = 1'b0;
    chk("wait_valid_low", {31'd0, cmd_valid}, 32'd0);
    chk("wait_cmd_data", cmd_data, 32'hA5);
    repeat (3) cyc();
    eng_done = 1'b1;
    cyc();
    eng_done = 1'b0;
    rd("done_status", 2'd2, 32'h02);
    chk("done_irq", {31'd0, irq}, 32'd1);
    chk("done_cmd_data", cmd_data, 32'hA5);
    wr(2'd2, 32'h02);
    chk("w1c_irq", {31'd0, irq}, 32'd0);
    rd("w1c_status", 2'd2, 32'h00);

    // watchdog: TIMEOUT=5, no completion
    wr(2'd3, 32'd5);
    push(32'hA5, 5, 1'b1);
    cmd_ready = 1'b1;
    wr(2'd0, 32'h5);
    cyc();
    cmd_ready = 1'b0;
    repeat (3) cyc();
    chk("to_busy_k4", {31'd0, busy}, 32'd1);
    cyc();
    chk("to_busy_k5", {31'd0, busy}, 32'd1);
    cyc();
    chk("to_busy_end", {31'd0, busy}, 32'd0);
    rd("to_status", 2'd2, 32'h08);
    wr(2'd2, 32'h1F);

    // watchdog disabled: stays busy until ABORT, which changes no status
    wr(2'd3, 32'd0);
    push(32'hA5, 21, 1'b0);
    cmd_ready = 1'b1;
    wr(2'd0, 32'h5);
    cyc();
    cmd_ready = 1'b0;
    repeat (20) cyc();
    chk("nowd_busy", {31'd0, busy}, 32'd1);
    wr(2'd0, 32'h6);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    rd("abort_status", 2'd2, 32'h00);

    // done with error on the cnt==1 cycle: done wins over expiry
    wr(2'd3, 32'd3);
    push(32'hA5, 3, 1'b1);
    cmd_ready = 1'b1;
    wr(2'd0, 32'h5);
    cyc();
    cmd_ready = 1'b0;
    repeat (2) cyc();
    eng_done = 1'b1; eng_error = 1'b1;
    cyc();
    eng_done = 1'b0; eng_error = 1'b0;
    rd("err_status", 2'd2, 32'h06);
    chk("err_irq", {31'd0, irq}, 32'd1);
    wr(2'd2, 32'h1F);

    // overrun: START and CMD writes while busy are ignored
    wr(2'd3, 32'd0);
    wr(2'd0, 32'h5);
    wr(2'd1, 32'h3C);
    wr(2'd0, 32'h5);
    rd("ovr_status", 2'd2, 32'h11);
    chk("ovr_irq", {31'd0, irq}, 32'd0);
    rd("ovr_cmd", 2'd1, 32'hA5);
    chk("ovr_cmd_data", cmd_data, 32'hA5);
    chk("ovr_valid", {31'd0, cmd_valid}, 32'd1);
    wr(2'd0, 32'h7);
    chk("sa_valid", {31'd0, cmd_valid}, 32'd0);
    chk("sa_busy", {31'd0, busy}, 32'd0);
    rd("sa_status", 2'd2, 32'h10);
    wr(2'd2, 32'h10);
    wr(2'd0, 32'h3);
    chk("sa_idle_busy", {31'd0, busy}, 32'd0);
    rd("sa_idle_status", 2'd2, 32'h00);
    rd("sa_idle_ctrl", 2'd0, 32'h00);

    // minimum-length transaction, then W1C racing a new DONE set
    wr(2'd0, 32'h4);
    push(32'hA5, 1, 1'b1);
    cmd_ready = 1'b1;
    wr(2'd0, 32'h5);
    cyc();
    cmd_ready = 1'b0;
    eng_done = 1'b1;
    cyc();
    eng_done = 1'b0;
    rd("min_status", 2'd2, 32'h02);
    push(32'hA5, 1, 1'b1);
    cmd_ready = 1'b1;
    wr(2'd0, 32'h5);
    cyc();
    cmd_ready = 1'b0;
    chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h02;
    eng_done = 1'b1;
    cyc();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    eng_done = 1'b0;
    rd("race_status", 2'd2, 32'h02);
    wr(2'd2, 32'h02);
    rd("race_clr_status", 2'd2, 32'h00);

    // engine signals outside WAIT are ignored
    eng_done = 1'b1; eng_error = 1'b1;
    repeat (2) cyc();
    eng_done = 1'b0; eng_error = 1'b0;
    rd("idle_done_status", 2'd2, 32'h00);
    chk("idle_done_irq", {31'd0, irq}, 32'd0);

    repeat (3) cyc();
    chk("q_cmd_drained", q_cmd.size(), 32'd0);
    chk("q_end_drained", q_end.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
